// File: rtl/utx_pkg.sv
// Shared types and constants for the serial-transmit scheduler.
package utx_pkg;

   localparam int UTX_GAP_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_BSY,
      S_WAIT_DONE,
      S_GAP
   } utx_sched_state_t;

endpackage

// File: rtl/utx_arb.sv
// Combinational arbiter: scans requests starting at i_ptr, returns one-hot grant plus index.
// With i_ptr tied to zero it degenerates to fixed lowest-index priority.
module utx_arb #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IW-1:0]    o_id,
   output logic             o_vld
);

   int   w_idx;
   logic w_found;

   always_comb begin
      o_gnt   = '0;
      o_id    = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = (int'(i_ptr) + k) % N_REQ;
         if (!w_found && i_req[w_idx]) begin
            w_found      = 1'b1;
            o_gnt[w_idx] = 1'b1;
            o_id         = IW'(w_idx);
         end
      end
      o_vld = w_found;
   end

endmodule

// File: rtl/utx_sched.sv
// Schedules N_REQ requesters onto one serial transmitter with an enforced inter-frame gap.
// Define UTX_SCHED_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module utx_sched
   import utx_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 6,
   parameter int GAP_CYC = 16
) (
   input  logic                       in_clk,
   input  logic                       in_rst,
   input  logic [N_REQ-1:0]           in_req,
   input  logic [N_REQ*DATA_W-1:0]    in_data,
   output logic [N_REQ-1:0]           out_ack,
   output logic [N_REQ-1:0]           out_done,
   output logic [DATA_W-1:0]          out_mem,
   output logic                       out_utx_st,
   input  logic                       in_utx_bs,
   output logic                       out_busy,
   output logic [$clog2(N_REQ)-1:0]   out_gnt_id
);

   localparam int IW = $clog2(N_REQ);
   localparam logic [UTX_GAP_W-1:0] GAP_LAST = UTX_GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   utx_sched_state_t       r_state, w_state_nxt;
   logic [N_REQ-1:0]       w_win_gnt, w_done_oh;
   logic [IW-1:0]          w_win_id, w_ptr;
   logic                   w_win_vld, w_latch, w_fin;
   logic [DATA_W-1:0]      w_win_data;

   logic [N_REQ-1:0]       r_ack, r_done;
   logic [DATA_W-1:0]      r_mem;
   logic                   r_st;
   logic [IW-1:0]          r_gnt_id;
   logic [UTX_GAP_W-1:0]   r_gap_cnt;

   utx_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .i_req (in_req),
      .i_ptr (w_ptr),
      .o_gnt (w_win_gnt),
      .o_id  (w_win_id),
      .o_vld (w_win_vld)
   );

`ifdef UTX_SCHED_RR_EN
   logic [IW-1:0] r_ptr;

   // Search for the next grant begins just past the last winner.
   always_ff @(posedge in_clk) begin
      if (in_rst)
         r_ptr <= '0;
      else if (w_latch)
         r_ptr <= (w_win_id == IW'(N_REQ - 1)) ? '0 : w_win_id + IW'(1);
   end

   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif

   assign w_win_data = in_data[int'(w_win_id)*DATA_W +: DATA_W];
   assign w_done_oh  = N_REQ'(1) << r_gnt_id;

   always_ff @(posedge in_clk) begin
      if (in_rst) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_fin       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_win_vld) begin
               w_latch     = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START:    w_state_nxt = S_WAIT_BSY;
         // Busy is only looked at from here on, so a stale busy during START is ignored.
         S_WAIT_BSY: if (in_utx_bs) w_state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (!in_utx_bs) begin
               w_fin       = 1'b1;
               w_state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP:      if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_ack     <= '0;
         r_done    <= '0;
         r_mem     <= '0;
         r_st      <= 1'b0;
         r_gnt_id  <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_ack  <= w_latch ? w_win_gnt : '0;
         r_done <= w_fin ? w_done_oh : '0;
         r_st   <= (r_state == S_START);
         if (w_latch) begin
            r_mem    <= w_win_data;
            r_gnt_id <= w_win_id;
         end
         r_gap_cnt <= (r_state == S_GAP && w_state_nxt == S_GAP) ? r_gap_cnt + UTX_GAP_W'(1) : '0;
      end
   end

   assign out_ack    = r_ack;
   assign out_done   = r_done;
   assign out_mem    = r_mem;
   assign out_utx_st = r_st;
   assign out_gnt_id = r_gnt_id;
   assign out_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_utx_sched.sv
// Bench for utx_sched: timestamp-based frame model checked every cycle, plus directed literal checks.
module tb_utx_sched;

   localparam int N   = 4;
   localparam int DW  = 6;
   localparam int GAP = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, ack, done;
   logic [N*DW-1:0] data;
   logic [DW-1:0]   mem;
   logic            st, bs, busy;
   logic [1:0]      gnt;

   logic [N-1:0]    g_req, g_ack, g_done;
   logic [N*DW-1:0] g_data;
   logic [DW-1:0]   g_mem;
   logic            g_st, g_bs, g_busy;
   logic [1:0]      g_gnt;

   utx_sched #(.N_REQ(N), .DATA_W(DW), .GAP_CYC(GAP)) u_dut (
      .in_clk(clk), .in_rst(rst), .in_req(req), .in_data(data),
      .out_ack(ack), .out_done(done), .out_mem(mem), .out_utx_st(st),
      .in_utx_bs(bs), .out_busy(busy), .out_gnt_id(gnt)
   );

   utx_sched #(.N_REQ(N), .DATA_W(DW), .GAP_CYC(0)) u_dut_g0 (
      .in_clk(clk), .in_rst(rst), .in_req(g_req), .in_data(g_data),
      .out_ack(g_ack), .out_done(g_done), .out_mem(g_mem), .out_utx_st(g_st),
      .in_utx_bs(g_bs), .out_busy(g_busy), .out_gnt_id(g_gnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int cyc = 0;
   int want[N], got[N], done_cnt[N];
   logic [DW-1:0] data_tab[N];
   int tx_dly = 1, tx_len = 20, tx_start = -1000;
   int g_want = 0, g_got = 0, g_tx_start = -1000;
   int ack_q[$];
   int n_acks = 0, st_cnt = 0;
   int last_ack_cyc = -1, last_st_cyc = -1, last_done_cyc = -1, last_idle_cyc = -1;
   int g_ack_cyc[$], g_done_cyc[$];
   logic prev_busy = 1'b0;
   bit chk_en = 1'b0;

   // frame model: timestamps of the current frame's events
   bit m_in_frame;
   int m_ack, m_rise, m_done, m_win, m_ptr, m_gnt_cur, m_gnt_nxt;
   logic [DW-1:0] m_mem_cur, m_mem_nxt;
   logic [N-1:0] e_ack, e_done;
   logic e_st, e_busy;
   logic [DW-1:0] e_mem;
   int e_gnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   // Input driver: requesters hold req until acked; transmitter busy window follows start.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #2;
      for (int i = 0; i < N; i++) begin
         req[i] = (want[i] > got[i]);
         data[i*DW +: DW] = data_tab[i];
      end
      bs    = (cyc >= tx_start) && (cyc < tx_start + tx_len);
      g_req = {1'b0, (g_want > g_got), 2'b00};
      g_bs  = (cyc >= g_tx_start) && (cyc < g_tx_start + 3);
   end

   function automatic int pick(input logic [N-1:0] r, input int ptr);
      int w;
      w = -1;
`ifdef UTX_SCHED_RR_EN
      for (int k = 0; k < N; k++)
         if (w < 0 && r[(ptr + k) % N]) w = (ptr + k) % N;
`else
      for (int k = N - 1; k >= 0; k--)
         if (r[k]) w = k;
`endif
      return w;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         e_ack  = (m_in_frame && cyc == m_ack) ? N'(1) << m_win : '0;
         e_st   = m_in_frame && (cyc == m_ack + 1);
         e_done = (m_in_frame && m_done >= 0 && cyc == m_done) ? N'(1) << m_win : '0;
         e_busy = m_in_frame && (cyc >= m_ack) && (m_done < 0 || cyc < m_done + GAP);
         e_mem  = (m_in_frame && cyc >= m_ack) ? m_mem_nxt : m_mem_cur;
         e_gnt  = (m_in_frame && cyc >= m_ack) ? m_gnt_nxt : m_gnt_cur;
         chk("ack", ack, e_ack);
         chk("done", done, e_done);
         chk("utx_st", st, e_st);
         chk("busy", busy, e_busy);
         chk("mem", mem, e_mem);
         chk("gnt_id", gnt, e_gnt);
         chk("ack_onehot", $countones(ack) <= 1, 1);
         chk("ack_done_excl", (ack != 0) && (done != 0), 0);

         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin got[i]++; ack_q.push_back(i); n_acks++; last_ack_cyc = cyc; end
            if (done[i]) begin done_cnt[i]++; last_done_cyc = cyc; end
         end
         if (st) begin st_cnt++; last_st_cyc = cyc; tx_start = cyc + tx_dly; end
         if (prev_busy && !busy) last_idle_cyc = cyc;
         prev_busy = busy;
         if (g_ack[2]) begin g_got++; g_ack_cyc.push_back(cyc); end
         if (g_st) g_tx_start = cyc + 1;
         if (g_done[2]) g_done_cyc.push_back(cyc);
      end

      if (rst) begin
         chk_en     = 1'b1;
         tx_start   = -1000;
         m_in_frame = 1'b0;
         m_ack = -10; m_rise = -1; m_done = -1; m_win = 0; m_ptr = 0;
         m_mem_cur = '0; m_mem_nxt = '0; m_gnt_cur = 0; m_gnt_nxt = 0;
      end else if (chk_en) begin
         if (!m_in_frame || (m_done >= 0 && cyc >= m_done + GAP)) begin
            if (req != '0) begin
               m_mem_cur  = e_mem;
               m_gnt_cur  = e_gnt;
               m_win      = pick(req, m_ptr);
               m_ptr      = (m_win + 1) % N;
               m_mem_nxt  = data[m_win*DW +: DW];
               m_gnt_nxt  = m_win;
               m_ack      = cyc + 1;
               m_rise     = -1;
               m_done     = -1;
               m_in_frame = 1'b1;
            end
         end else if (m_rise < 0) begin
            if (cyc >= m_ack + 1 && bs) m_rise = cyc;
         end else if (m_done < 0) begin
            if (cyc > m_rise && !bs) m_done = cyc + 1;
         end
      end
   end

   task automatic wait_acks(input int n, input string nm);
      int t;
      t = 0;
      while (n_acks < n && t < 2000) begin @(negedge clk); #1; t++; end
      chk(nm, n_acks >= n, 1);
   endtask

   task automatic wait_idle(input string nm);
      int t;
      bit pend;
      t = 0;
      pend = 1'b1;
      while (pend && t < 2000) begin
         @(negedge clk); #1; t++;
         pend = busy;
         for (int i = 0; i < N; i++) if (want[i] > got[i]) pend = 1'b1;
      end
      chk(nm, pend, 0);
   endtask

   function automatic int qget(input int idx);
      return (idx < ack_q.size()) ? ack_q[idx] : -1;
   endfunction

   initial begin
      int r, base, s0, d0;
      int exp_hold[4];
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         want[i] = 0; got[i] = 0; done_cnt[i] = 0; data_tab[i] = DW'(i * 8 + 5);
      end
      g_data = '0;
      g_data[2*DW +: DW] = 6'h33;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_mem", mem, 0);
      chk("rst_gnt", gnt, 0);

      // single requester, default gap; GAP_CYC=0 instance runs back-to-back alongside
      data_tab[0] = 6'h2A;
      @(posedge clk); #1;
      want[0] = 1; g_want = 2; r = cyc;
      wait_acks(1, "t1_ack_timeout");
      wait_idle("t1_idle_timeout");
      chk("t1_ack_lat", last_ack_cyc, r + 1);
      chk("t1_st_lat", last_st_cyc, r + 2);
      chk("t1_st_cnt", st_cnt, 1);
      chk("t1_winner", qget(0), 0);
      chk("t1_mem", mem, 6'h2A);
      chk("t1_done_cnt", done_cnt[0], 1);
      chk("t1_done_cyc", last_done_cyc, r + 2 + 22);
      chk("t1_gap_len", last_idle_cyc - last_done_cyc, 16);
      chk("g0_acks", g_ack_cyc.size(), 2);
      chk("g0_dones", g_done_cyc.size(), 2);
      chk("g0_b2b", (g_ack_cyc.size() > 1 && g_done_cyc.size() > 0) ? g_ack_cyc[1] - g_done_cyc[0] : -1, 1);
      chk("g0_gnt", g_gnt, 2);
      chk("g0_mem", g_mem, 6'h33);

      // late transmitter busy: one start only
      tx_dly = 5; s0 = st_cnt; data_tab[0] = 6'h15;
      want[0]++;
      wait_acks(2, "t2_ack_timeout");
      wait_idle("t2_idle_timeout");
      chk("t2_st_once", st_cnt, s0 + 1);
      chk("t2_done_cnt", done_cnt[0], 2);
      chk("t2_done_dist", last_done_cyc - last_st_cyc, 26);
      chk("t2_mem", mem, 6'h15);
      tx_dly = 1; tx_len = 4;

      // req[1] and req[3] together, then re-request after grant 3
      base = ack_q.size();
      want[1]++; want[3]++;
      wait_acks(base + 2, "t3_ack_timeout");
      want[1]++; want[3]++;
      wait_acks(base + 4, "t3_ack2_timeout");
      wait_idle("t3_idle_timeout");
      chk("t3_ord0", qget(base), 1);
      chk("t3_ord1", qget(base + 1), 3);
      chk("t3_ord2", qget(base + 2), 1);
      chk("t3_ord3", qget(base + 3), 3);

      // req[0] and req[1] held continuously
`ifdef UTX_SCHED_RR_EN
      exp_hold = '{0, 1, 0, 1};
`else
      exp_hold = '{0, 0, 0, 0};
`endif
      base = ack_q.size();
      want[0] = got[0] + 100; want[1] = got[1] + 100;
      wait_acks(base + 4, "t4_ack_timeout");
      want[0] = got[0]; want[1] = got[1];
      wait_idle("t4_idle_timeout");
      chk("t4_count", ack_q.size(), base + 4);
      for (int k = 0; k < 4; k++) chk("t4_order", qget(base + k), exp_hold[k]);

      // req[2] raised and dropped during another frame
      base = ack_q.size(); d0 = done_cnt[2]; r = got[2];
      want[1]++;
      wait_acks(base + 1, "t5_ack_timeout");
      want[2]++;
      repeat (3) @(negedge clk);
      #1 want[2] = got[2];
      wait_idle("t5_idle_timeout");
      chk("t5_no_ack2", got[2], r);
      chk("t5_no_done2", done_cnt[2], d0);
      chk("t5_count", ack_q.size(), base + 1);

      // reset while waiting for transmitter to finish
      tx_len = 10;
      base = ack_q.size(); d0 = done_cnt[3];
      want[3]++;
      wait_acks(base + 1, "t6_ack_timeout");
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_mem", mem, 0);
      chk("t6_rst_gnt", gnt, 0);
      chk("t6_rst_ack", ack, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_st", st, 0);
      repeat (15) @(negedge clk);
      #1 chk("t6_no_done", done_cnt[3], d0);
      tx_len = 4;
      want[3]++;
      wait_acks(base + 2, "t6_ack2_timeout");
      wait_idle("t6_idle_timeout");
      chk("t6_reserve", qget(base + 1), 3);
      chk("t6_done_after", done_cnt[3], d0 + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/utx_sched.md
UTX_SCHED -- requirements
Module: utx_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one serial transmitter (2..8).
REQ-002 Parameter DATA_W, default 6, width of one transmit word.
REQ-003 Parameter GAP_CYC, default 16, idle clock cycles enforced between frames (0..255).
REQ-004 in_clk  input  1  single clock; all logic on rising edge.
REQ-005 in_rst  input  1  reset, synchronous, active-high.
REQ-006 in_req  input  N_REQ  per-requester request; held high with stable data until acknowledged.
REQ-007 in_data  input  N_REQ*DATA_W  per-requester word; slice i = bits [i*DATA_W +: DATA_W].
REQ-008 out_ack  output  N_REQ  one-cycle pulse: word of requester i latched.
REQ-009 out_done  output  N_REQ  one-cycle pulse: frame of requester i fully shifted out.
REQ-010 out_mem  output  DATA_W  word to transmitter, registered, stable from START until next latch.
REQ-011 out_utx_st  output  1  transmitter start strobe, one cycle.
REQ-012 in_utx_bs  input  1  transmitter busy flag.
REQ-013 out_busy  output  1  high in every state except IDLE.
REQ-014 out_gnt_id  output  $clog2(N_REQ)  index of requester currently being served.

Function
REQ-015 FSM states: IDLE, START, WAIT_BSY, WAIT_DONE, GAP.
REQ-016 IDLE: if any in_req bit set, select winner, latch its word into out_mem, set out_gnt_id, pulse out_ack[winner], go START next cycle.
REQ-017 START: out_utx_st=1 for exactly one cycle; next state WAIT_BSY.
REQ-018 WAIT_BSY: stay until in_utx_bs=1, then WAIT_DONE; in_utx_bs=1 already in START cycle is not sampled.
REQ-019 WAIT_DONE: on in_utx_bs=0, pulse out_done[out_gnt_id], go GAP (or IDLE if GAP_CYC=0).
REQ-020 GAP: 8-bit counter from 0; leave to IDLE when counter reaches GAP_CYC-1, giving exactly GAP_CYC cycles.
REQ-021 Arbitration decided only in IDLE; requests arriving or dropping in other states do not affect the current frame.
REQ-022 Requester dropping in_req before out_ack is never served; no ack or done generated for it.
REQ-023 Request latency: in_req rising in IDLE with no competitors -> out_ack same cycle the FSM leaves IDLE (1 cycle after sampling), out_utx_st 1 cycle later.
REQ-024 At most one bit of out_ack and out_done high per cycle; out_ack and out_done never high in the same cycle.

Reset
REQ-025 in_rst=1 sampled: state IDLE, out_ack=0, out_done=0, out_utx_st=0, out_busy=0, out_mem=0, out_gnt_id=0, gap counter=0, round-robin pointer=0.
REQ-026 Reset mid-frame aborts without out_done; transmitter is reset by the same in_rst.

Configuration
REQ-027 Macro UTX_SCHED_RR_EN defined: round-robin; search starts at (last winner+1) mod N_REQ; pointer updates on each ack.
REQ-028 Macro undefined: fixed priority, lowest index wins; no pointer register.

Structure
REQ-029 Shared package utx_pkg holds the state enum type utx_sched_state_t and constant UTX_GAP_W=8.
REQ-030 One sub-module utx_arb (combinational request->one-hot grant plus index, RR pointer input) is natural; FSM, counter and registers stay in utx_sched.

Verification
REQ-031 Single req[0] data 6'h2A, transmitter model busy 1 cycle after start for 20 cycles -> ack[0] once, st once, out_mem=6'h2A, done[0] after busy falls, out_busy low GAP_CYC cycles after done.
REQ-032 req[1] and req[3] asserted together, RR build -> serve order 1,3; fixed-priority build -> 1,3; then re-request both after grant 3 -> RR serves 1 then 3, fixed 1 then 3; with req[0],req[1] held continuously RR alternates 0,1,0,1, fixed serves 0 only.
REQ-033 GAP_CYC=0, back-to-back req[2] -> next ack in cycle immediately after done[2].
REQ-034 Transmitter model delays busy 5 cycles -> FSM holds WAIT_BSY, single st pulse, no duplicate start.
REQ-035 in_rst asserted during WAIT_DONE -> next cycle all outputs at reset values, no done pulse; new req served normally afterwards.
REQ-036 req[2] dropped during another requester's frame -> never acked, no stray done.
